// File: rtl/unified_cache_port_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// unified_cache_port_arbiter_pkg
//   Packet layout shared by the unified cache port arbiter and its clients.
//   A packet is a flat vector; the arbiter only interprets the valid bit and
//   the port-ID field, everything else is carried through untouched.
//
//   Layout (LSB first):
//     [0]      valid
//     [3:1]    port ID
//     [35:4]   address
//     [63:36]  data / payload
// -----------------------------------------------------------------------------
package unified_cache_port_arbiter_pkg;

    localparam int PKT_WIDTH_DEFAULT         = 64;
    localparam int PKT_VALID_POS             = 0;
    localparam int PKT_PORT_ID_POS_LO        = 1;
    localparam int PKT_PORT_ID_POS_HI        = 3;
    localparam int PKT_PORT_ID_WIDTH_DEFAULT = PKT_PORT_ID_POS_HI - PKT_PORT_ID_POS_LO + 1;
    localparam int PKT_ADDR_WIDTH            = 32;
    localparam int PKT_DATA_WIDTH            = PKT_WIDTH_DEFAULT - PKT_ADDR_WIDTH
                                               - PKT_PORT_ID_WIDTH_DEFAULT - 1;

    typedef logic [PKT_PORT_ID_WIDTH_DEFAULT-1:0] port_id_t;
    typedef logic [PKT_ADDR_WIDTH-1:0]            addr_t;
    typedef logic [PKT_DATA_WIDTH-1:0]            data_t;

    typedef struct packed {
        data_t    data;
        addr_t    addr;
        port_id_t port_id;
        logic     valid;
    } packet_t;

    // Assemble a packet from its fields; used by clients and packet generators.
    function automatic packet_t make_packet(input logic     valid,
                                            input port_id_t port_id,
                                            input addr_t    addr,
                                            input data_t    data);
        packet_t p;
        p.valid   = valid;
        p.port_id = port_id;
        p.addr    = addr;
        p.data    = data;
        return p;
    endfunction

endpackage

// File: rtl/round_robin_picker.sv
// -----------------------------------------------------------------------------
// round_robin_picker
//   Combinational round-robin selector: picks the first set bit of `eligible`
//   searching from `rr_ptr` upward with wrap-around.
//
//   Ports:
//     eligible      in   NUM_REQUESTER  requesters that may be granted
//     rr_ptr        in   PTR_W          highest-priority index this cycle
//     grant_valid   out  1              at least one requester is eligible
//     grant_onehot  out  NUM_REQUESTER  one-hot grant (zero when none)
//     grant_idx     out  PTR_W          index of the granted requester
// -----------------------------------------------------------------------------
module round_robin_picker #(
    parameter int NUM_REQUESTER = 4,
    parameter int PTR_W         = 2
) (
    input  logic [NUM_REQUESTER-1:0] eligible,
    input  logic [PTR_W-1:0]         rr_ptr,
    output logic                     grant_valid,
    output logic [NUM_REQUESTER-1:0] grant_onehot,
    output logic [PTR_W-1:0]         grant_idx
);

    logic [PTR_W-1:0] upper_idx;
    logic [PTR_W-1:0] lower_idx;
    logic             upper_found;
    logic             any_found;

    // Split the search in two: the lowest eligible index at or above rr_ptr
    // wins; otherwise wrap and take the lowest eligible index overall.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        upper_idx   = '0;
        lower_idx   = '0;
        upper_found = 1'b0;
        any_found   = 1'b0;
        // Descending scan: the last hit written is the lowest index.
        for (int i = NUM_REQUESTER - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                lower_idx = PTR_W'(i);
                any_found = 1'b1;
                if (i >= int'(rr_ptr)) begin
                    upper_idx   = PTR_W'(i);
                    upper_found = 1'b1;
                end
            end
        end
        grant_valid  = any_found;
        grant_idx    = upper_found ? upper_idx : lower_idx;
        grant_onehot = any_found ? (NUM_REQUESTER'(1) << grant_idx) : '0;
    end

endmodule

// File: rtl/unified_cache_port_arbiter.sv
// -----------------------------------------------------------------------------
// unified_cache_port_arbiter
//   Shares the unified cache's single request port and single return port
//   among NUM_REQUESTER packet-level requesters. Requests are granted
//   round-robin, stamped with the requester index in the port-ID field and
//   registered toward the cache. Cache returns are steered to a one-entry
//   return buffer per requester, selected by their port-ID field.
//
//   Ports:
//     clk_in                            in   1      clock
//     reset_in                          in   1      async active-low reset
//     request_packet_flatted_in         in   PW*N   request packet per requester
//     request_packet_ack_flatted_out    out  N      one-cycle accept pulse per requester
//     return_packet_flatted_out         out  PW*N   return packet per requester
//     return_packet_ack_flatted_in      in   N      requester consumed its return packet
//     request_packet_to_cache_out       out  PW     granted packet toward the cache
//     request_packet_ack_from_cache_in  in   1      cache accepted the packet
//     return_packet_from_cache_in       in   PW     return packet from the cache
//     return_packet_ack_to_cache_out    out  1      one-cycle accept pulse to the cache
//     port_id_error_out                 out  1      sticky: return carried port ID >= N
// -----------------------------------------------------------------------------
module unified_cache_port_arbiter
    import unified_cache_port_arbiter_pkg::*;
#(
    parameter int NUM_REQUESTER                      = 4,
    parameter int UNIFIED_CACHE_PACKET_WIDTH_IN_BITS = PKT_WIDTH_DEFAULT,
    parameter int UNIFIED_CACHE_PACKET_PORT_ID_WIDTH = PKT_PORT_ID_WIDTH_DEFAULT
) (
    input  logic                                                    clk_in,
    input  logic                                                    reset_in,
    input  logic [UNIFIED_CACHE_PACKET_WIDTH_IN_BITS*NUM_REQUESTER-1:0] request_packet_flatted_in,
    output logic [NUM_REQUESTER-1:0]                                request_packet_ack_flatted_out,
    output logic [UNIFIED_CACHE_PACKET_WIDTH_IN_BITS*NUM_REQUESTER-1:0] return_packet_flatted_out,
    input  logic [NUM_REQUESTER-1:0]                                return_packet_ack_flatted_in,
    output logic [UNIFIED_CACHE_PACKET_WIDTH_IN_BITS-1:0]           request_packet_to_cache_out,
    input  logic                                                    request_packet_ack_from_cache_in,
    input  logic [UNIFIED_CACHE_PACKET_WIDTH_IN_BITS-1:0]           return_packet_from_cache_in,
    output logic                                                    return_packet_ack_to_cache_out,
    output logic                                                    port_id_error_out
);

    localparam int PW    = UNIFIED_CACHE_PACKET_WIDTH_IN_BITS;
    localparam int PID_W = UNIFIED_CACHE_PACKET_PORT_ID_WIDTH;
    localparam int PTR_W = (NUM_REQUESTER > 1) ? $clog2(NUM_REQUESTER) : 1;

    // Per-requester views of the flattened buses.
    logic [NUM_REQUESTER-1:0][PW-1:0] req_pkts;
    logic [NUM_REQUESTER-1:0][PW-1:0] ret_bufs;

    assign req_pkts                  = request_packet_flatted_in;
    assign return_packet_flatted_out = ret_bufs;

    // ------------------------------------------------------------------ request
    logic [NUM_REQUESTER-1:0] eligible;
    logic [NUM_REQUESTER-1:0] grant_onehot;
    logic [PTR_W-1:0]         grant_idx;
    logic                     grant_valid;
    logic [PTR_W-1:0]         rr_ptr;
    logic [PTR_W-1:0]         rr_next;
    logic [PW-1:0]            granted_pkt;
    logic                     buffer_can_load;
    logic                     do_grant;

    // A requester whose ack is high this cycle is about to drop the packet we
    // already took, so it must not be granted again.
    always_comb begin
        eligible = '0;
        for (int i = 0; i < NUM_REQUESTER; i++) begin
            eligible[i] = req_pkts[i][PKT_VALID_POS] & ~request_packet_ack_flatted_out[i];
        end
    end

    round_robin_picker #(
        .NUM_REQUESTER (NUM_REQUESTER),
        .PTR_W         (PTR_W)
    ) u_picker (
        .eligible     (eligible),
        .rr_ptr       (rr_ptr),
        .grant_valid  (grant_valid),
        .grant_onehot (grant_onehot),
        .grant_idx    (grant_idx)
    );

    assign buffer_can_load = ~request_packet_to_cache_out[PKT_VALID_POS]
                           | request_packet_ack_from_cache_in;
    assign do_grant        = buffer_can_load & grant_valid;
    assign rr_next         = (grant_idx == PTR_W'(NUM_REQUESTER - 1)) ? '0
                                                                      : grant_idx + PTR_W'(1);

    // The cache routes the return by port ID, so overwrite whatever the
    // requester put there with its own index.
    always_comb begin
        granted_pkt = req_pkts[grant_idx];
        granted_pkt[PKT_PORT_ID_POS_LO +: PID_W] = PID_W'(grant_idx);
    end

    always_ff @(posedge clk_in or negedge reset_in) begin
        if (!reset_in) begin
            request_packet_to_cache_out    <= '0;
            request_packet_ack_flatted_out <= '0;
            rr_ptr                         <= '0;
        end else begin
            // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
            request_packet_ack_flatted_out <= do_grant ? grant_onehot : '0;
            if (do_grant) begin
                request_packet_to_cache_out <= granted_pkt;
                rr_ptr                      <= rr_next;
            end else if (request_packet_ack_from_cache_in) begin
                request_packet_to_cache_out <= '0;
            end
        end
    end

    // ------------------------------------------------------------------- return
    logic [PID_W-1:0]         ret_pid;
    logic                     ret_offered;
    logic                     ret_pid_in_range;
    logic [NUM_REQUESTER-1:0] ret_sel;
    logic [NUM_REQUESTER-1:0] ret_slot_ready;
    logic                     ret_accept;
    logic                     ret_bad;

    assign ret_pid     = return_packet_from_cache_in[PKT_PORT_ID_POS_LO +: PID_W];
    // While our ack pulse is high the cache is still retiring the packet we
    // just took; looking at it again would accept it twice.
    assign ret_offered = return_packet_from_cache_in[PKT_VALID_POS] & ~return_packet_ack_to_cache_out;
    assign ret_pid_in_range = int'(ret_pid) < NUM_REQUESTER;

    always_comb begin
        ret_sel        = '0;
        ret_slot_ready = '0;
        for (int i = 0; i < NUM_REQUESTER; i++) begin
            ret_sel[i]        = (int'(ret_pid) == i);
            ret_slot_ready[i] = ~ret_bufs[i][PKT_VALID_POS] | return_packet_ack_flatted_in[i];
        end
    end

    assign ret_accept = ret_offered & ret_pid_in_range & |(ret_sel & ret_slot_ready);
    assign ret_bad    = ret_offered & ~ret_pid_in_range;

    always_ff @(posedge clk_in or negedge reset_in) begin
        if (!reset_in) begin
            // NOTE: the return buffers are plain registers, not RAM, so they are reset to a known empty state.
            ret_bufs                       <= '0;
            return_packet_ack_to_cache_out <= 1'b0;
            port_id_error_out              <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_REQUESTER; i++) begin
                if (ret_accept && ret_sel[i]) begin
                    ret_bufs[i] <= return_packet_from_cache_in;
                end else if (return_packet_ack_flatted_in[i]) begin
                    ret_bufs[i] <= '0;
                end
            end
            // Bad port IDs are acked too so the cache never stalls on them.
            return_packet_ack_to_cache_out <= ret_accept | ret_bad;
            port_id_error_out              <= port_id_error_out | ret_bad;
        end
    end

endmodule

// File: tb/tb_unified_cache_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_unified_cache_port_arbiter
//   Directed, table-driven bench for the request path plus hand-written
//   sequences for return routing, back-pressure, bad port ID and async reset.
// -----------------------------------------------------------------------------
module tb_unified_cache_port_arbiter;
    import unified_cache_port_arbiter_pkg::*;

    localparam int N  = 4;
    localparam int PW = PKT_WIDTH_DEFAULT;
    localparam int CW = N * PW;

    typedef logic [CW-1:0] cval_t;

    logic              clk_in;
    logic              reset_in;
    logic [N*PW-1:0]   request_packet_flatted_in;
    logic [N-1:0]      request_packet_ack_flatted_out;
    logic [N*PW-1:0]   return_packet_flatted_out;
    logic [N-1:0]      return_packet_ack_flatted_in;
    logic [PW-1:0]     request_packet_to_cache_out;
    logic              request_packet_ack_from_cache_in;
    logic [PW-1:0]     return_packet_from_cache_in;
    logic              return_packet_ack_to_cache_out;
    logic              port_id_error_out;

    int checks   = 0;
    int failures = 0;

    unified_cache_port_arbiter #(
        .NUM_REQUESTER                      (N),
        .UNIFIED_CACHE_PACKET_WIDTH_IN_BITS (PW),
        .UNIFIED_CACHE_PACKET_PORT_ID_WIDTH (PKT_PORT_ID_WIDTH_DEFAULT)
    ) dut (
        .clk_in                           (clk_in),
        .reset_in                         (reset_in),
        .request_packet_flatted_in        (request_packet_flatted_in),
        .request_packet_ack_flatted_out   (request_packet_ack_flatted_out),
        .return_packet_flatted_out        (return_packet_flatted_out),
        .return_packet_ack_flatted_in     (return_packet_ack_flatted_in),
        .request_packet_to_cache_out      (request_packet_to_cache_out),
        .request_packet_ack_from_cache_in (request_packet_ack_from_cache_in),
        .return_packet_from_cache_in      (return_packet_from_cache_in),
        .return_packet_ack_to_cache_out   (return_packet_ack_to_cache_out),
        .port_id_error_out                (port_id_error_out)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    typedef struct {
        logic [N-1:0] req_valid;
        logic         cache_ack;
        logic         exp_valid;
        int           exp_port;
        logic [N-1:0] exp_ack;
    } req_vec_t;

    req_vec_t vecs[16];

    task automatic check(input string name, input cval_t act, input cval_t exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic set_req(input int i, input logic [PW-1:0] pkt);
        request_packet_flatted_in[i*PW +: PW] = pkt;
    endtask

    // Requester i always offers this packet, with a bogus port ID of 7.
    function automatic logic [PW-1:0] req_pkt(input int i);
        return make_packet(1'b1, port_id_t'(7), addr_t'(32'h100 * (i + 1)), data_t'(i + 'hA0));
    endfunction

    // What the cache must see after requester k is granted.
    function automatic logic [PW-1:0] exp_pkt(input int k);
        return make_packet(1'b1, port_id_t'(k), addr_t'(32'h100 * (k + 1)), data_t'(k + 'hA0));
    endfunction

    function automatic cval_t ret_slice(input int i, input logic [PW-1:0] pkt);
        cval_t v;
        v = '0;
        v[i*PW +: PW] = pkt;
        return v;
    endfunction

    task automatic check_all_zero(input string tag);
        check({tag, "_to_cache"}, cval_t'(request_packet_to_cache_out), '0);
        check({tag, "_req_ack"},  cval_t'(request_packet_ack_flatted_out), '0);
        check({tag, "_ret_flat"}, cval_t'(return_packet_flatted_out), '0);
        check({tag, "_ret_ack"},  cval_t'(return_packet_ack_to_cache_out), '0);
        check({tag, "_err"},      cval_t'(port_id_error_out), '0);
    endtask

    logic [PW-1:0] pkt_a;
    logic [PW-1:0] pkt_b;
    int            pulses;

    initial begin
        // Request path: rr_ptr starts at 0 after reset.
        vecs[0]  = '{4'b1111, 1'b0, 1'b1, 0, 4'b0001};
        vecs[1]  = '{4'b1111, 1'b1, 1'b1, 1, 4'b0010};
        vecs[2]  = '{4'b1111, 1'b1, 1'b1, 2, 4'b0100};
        vecs[3]  = '{4'b1111, 1'b1, 1'b1, 3, 4'b1000};
        vecs[4]  = '{4'b1111, 1'b1, 1'b1, 0, 4'b0001};
        vecs[5]  = '{4'b1111, 1'b0, 1'b1, 0, 4'b0000};  // cache stalls: hold
        vecs[6]  = '{4'b1111, 1'b0, 1'b1, 0, 4'b0000};
        vecs[7]  = '{4'b1111, 1'b1, 1'b1, 1, 4'b0010};
        vecs[8]  = '{4'b0001, 1'b1, 1'b1, 0, 4'b0001};  // lone requester below rr_ptr
        vecs[9]  = '{4'b0001, 1'b1, 1'b0, 0, 4'b0000};  // masked by own ack: drain
        vecs[10] = '{4'b0001, 1'b0, 1'b1, 0, 4'b0001};
        vecs[11] = '{4'b0000, 1'b1, 1'b0, 0, 4'b0000};
        vecs[12] = '{4'b1000, 1'b0, 1'b1, 3, 4'b1000};
        vecs[13] = '{4'b1001, 1'b1, 1'b1, 0, 4'b0001};
        vecs[14] = '{4'b1001, 1'b1, 1'b1, 3, 4'b1000};
        vecs[15] = '{4'b0000, 1'b1, 1'b0, 0, 4'b0000};

        reset_in                         = 1'b0;
        request_packet_flatted_in        = '0;
        return_packet_ack_flatted_in     = '0;
        request_packet_ack_from_cache_in = 1'b0;
        return_packet_from_cache_in      = '0;

        #12;
        check_all_zero("reset");
        reset_in = 1'b1;
        tick();

        // ---- table-driven request arbitration
        for (int v = 0; v < 16; v++) begin
            for (int i = 0; i < N; i++) begin
                set_req(i, vecs[v].req_valid[i] ? req_pkt(i) : '0);
            end
            request_packet_ack_from_cache_in = vecs[v].cache_ack;
            tick();
            check($sformatf("vec%0d_to_cache", v), cval_t'(request_packet_to_cache_out),
                  cval_t'(vecs[v].exp_valid ? exp_pkt(vecs[v].exp_port) : '0));
            check($sformatf("vec%0d_req_ack", v), cval_t'(request_packet_ack_flatted_out),
                  cval_t'(vecs[v].exp_ack));
        end
        request_packet_ack_from_cache_in = 1'b0;

        // ---- single requester: port ID stamped, one-cycle ack, drain on cache ack
        set_req(2, make_packet(1'b1, port_id_t'(0), addr_t'(32'h1000), data_t'(0)));
        tick();
        check("single_to_cache", cval_t'(request_packet_to_cache_out),
              cval_t'(make_packet(1'b1, port_id_t'(2), addr_t'(32'h1000), data_t'(0))));
        check("single_ack", cval_t'(request_packet_ack_flatted_out), cval_t'(4'b0100));
        set_req(2, '0);
        request_packet_ack_from_cache_in = 1'b1;
        tick();
        check("single_ack_drop", cval_t'(request_packet_ack_flatted_out), '0);
        check("single_drain", cval_t'(request_packet_to_cache_out), '0);
        request_packet_ack_from_cache_in = 1'b0;

        // ---- return routing to ports 1 and 3
        pulses = 0;
        pkt_a  = make_packet(1'b1, port_id_t'(1), addr_t'(32'hAAA0), data_t'('h11));
        pkt_b  = make_packet(1'b1, port_id_t'(3), addr_t'(32'hBBB0), data_t'('h33));
        return_packet_from_cache_in = pkt_a;
        tick();
        pulses += int'(return_packet_ack_to_cache_out);
        check("route_p1", cval_t'(return_packet_flatted_out), ret_slice(1, pkt_a));
        return_packet_from_cache_in  = pkt_b;
        return_packet_ack_flatted_in = 4'b0010;
        tick();
        pulses += int'(return_packet_ack_to_cache_out);
        check("route_p1_consumed", cval_t'(return_packet_flatted_out), '0);
        return_packet_ack_flatted_in = '0;
        tick();
        pulses += int'(return_packet_ack_to_cache_out);
        check("route_p3", cval_t'(return_packet_flatted_out), ret_slice(3, pkt_b));
        return_packet_from_cache_in  = '0;
        return_packet_ack_flatted_in = 4'b1000;
        tick();
        pulses += int'(return_packet_ack_to_cache_out);
        check("route_p3_consumed", cval_t'(return_packet_flatted_out), '0);
        check("route_pulses", cval_t'(pulses), cval_t'(2));
        return_packet_ack_flatted_in = '0;

        // ---- return back-pressure on port 0
        pkt_a = make_packet(1'b1, port_id_t'(0), addr_t'(32'hB000), data_t'(1));
        pkt_b = make_packet(1'b1, port_id_t'(0), addr_t'(32'hB100), data_t'(2));
        return_packet_from_cache_in = pkt_a;
        tick();
        check("bp_first_ack", cval_t'(return_packet_ack_to_cache_out), cval_t'(1));
        check("bp_first_data", cval_t'(return_packet_flatted_out), ret_slice(0, pkt_a));
        return_packet_from_cache_in = pkt_b;
        for (int k = 0; k < 5; k++) begin
            tick();
            check($sformatf("bp_wait%0d_ack", k), cval_t'(return_packet_ack_to_cache_out), '0);
            check($sformatf("bp_wait%0d_data", k), cval_t'(return_packet_flatted_out),
                  ret_slice(0, pkt_a));
        end
        return_packet_ack_flatted_in = 4'b0001;
        tick();
        check("bp_second_ack", cval_t'(return_packet_ack_to_cache_out), cval_t'(1));
        check("bp_second_data", cval_t'(return_packet_flatted_out), ret_slice(0, pkt_b));
        return_packet_ack_flatted_in = '0;
        return_packet_from_cache_in  = '0;
        tick();
        check("bp_second_held", cval_t'(return_packet_flatted_out), ret_slice(0, pkt_b));
        return_packet_ack_flatted_in = 4'b0001;
        tick();
        check("bp_cleared", cval_t'(return_packet_flatted_out), '0);
        return_packet_ack_flatted_in = '0;

        // ---- bad port ID
        check("err_before", cval_t'(port_id_error_out), '0);
        return_packet_from_cache_in = make_packet(1'b1, port_id_t'(7), addr_t'(32'hC000), data_t'(3));
        tick();
        check("bad_ack", cval_t'(return_packet_ack_to_cache_out), cval_t'(1));
        check("bad_err", cval_t'(port_id_error_out), cval_t'(1));
        check("bad_dropped", cval_t'(return_packet_flatted_out), '0);
        return_packet_from_cache_in = '0;
        tick();
        check("bad_ack_drop", cval_t'(return_packet_ack_to_cache_out), '0);
        tick();
        tick();
        check("bad_err_sticky", cval_t'(port_id_error_out), cval_t'(1));

        // ---- asynchronous reset with packets buffered on both paths
        pkt_a = make_packet(1'b1, port_id_t'(2), addr_t'(32'hD000), data_t'(4));
        return_packet_from_cache_in = pkt_a;
        tick();
        return_packet_from_cache_in = '0;
        set_req(1, req_pkt(1));
        tick();
        check("pre_reset_to_cache", cval_t'(request_packet_to_cache_out), cval_t'(exp_pkt(1)));
        check("pre_reset_ret", cval_t'(return_packet_flatted_out), ret_slice(2, pkt_a));
        set_req(1, '0);
        #3;
        reset_in = 1'b0;
        #1;
        check_all_zero("async_reset");
        #2;
        for (int i = 0; i < N; i++) set_req(i, req_pkt(i));
        reset_in = 1'b1;
        tick();
        check("post_reset_to_cache", cval_t'(request_packet_to_cache_out), cval_t'(exp_pkt(0)));
        check("post_reset_ack", cval_t'(request_packet_ack_flatted_out), cval_t'(4'b0001));
        request_packet_flatted_in = '0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/unified_cache_port_arbiter.md
# unified_cache_port_arbiter

Shares the single request port and single return port of the unified cache among `NUM_REQUESTER` packet-level requesters. Each cycle it grants one valid request packet round-robin and stamps the requester index into the packet's port-ID field. It registers the packet toward the cache and steers each cache return packet back to the requester named in its port-ID field. It sits between the L1-side clients (or a packet generator in test) and the unified cache's request/return packet ports.

## Interface
- `NUM_REQUESTER`, 4: number of requester ports; must be ≥ 2 and ≤ 2^`UNIFIED_CACHE_PACKET_PORT_ID_WIDTH`.
- `UNIFIED_CACHE_PACKET_WIDTH_IN_BITS`, `` `UNIFIED_CACHE_PACKET_WIDTH_IN_BITS ``: packet width.
- `UNIFIED_CACHE_PACKET_PORT_ID_WIDTH`, `` `UNIFIED_CACHE_PACKET_PORT_ID_WIDTH ``: port-ID field width.

Ports (clock and reset first):
- `clk_in`  in  1  single clock.
- `reset_in`  in  1  asynchronous, active-low reset.
- `request_packet_flatted_in`  in  PW*N  request packet per requester; packet i occupies slice i.
- `request_packet_ack_flatted_out`  out  N  one-cycle accept pulse per requester.
- `return_packet_flatted_out`  out  PW*N  return packet per requester.
- `return_packet_ack_flatted_in`  in  N  requester consumed its return packet.
- `request_packet_to_cache_out`  out  PW  granted packet toward the cache.
- `request_packet_ack_from_cache_in`  in  1  cache accepted the packet.
- `return_packet_from_cache_in`  in  PW  return packet from the cache.
- `return_packet_ack_to_cache_out`  out  1  one-cycle accept pulse toward the cache.
- `port_id_error_out`  out  1  sticky; set when a return packet carries a port ID ≥ N.

## Operation
- **Validity.** A packet is valid when its `` `UNIFIED_CACHE_PACKET_VALID_POS `` bit is 1. An empty slot holds all zeros.
- **Eligible requester.** Requester i is eligible when its packet is valid and `request_packet_ack_flatted_out[i]` is 0 in the current cycle. Masking on the ack prevents re-accepting a packet the requester is about to drop.
- **Request buffer.** The request buffer is a single register driving `request_packet_to_cache_out`. It can load at an edge when it is empty, or when it is valid and the cache ack is high at that edge.
- **Grant.** When the buffer can load, the arbiter grants the first eligible requester searching from `rr_ptr` upward, with wrap-around. At that edge:
  - The buffer loads the requester's packet with the port-ID field (`` `UNIFIED_CACHE_PACKET_PORT_ID_POS_LO ``…`HI`) replaced by the requester index, zero-extended.
  - `request_packet_ack_flatted_out[i]` is set for exactly one cycle.
  - `rr_ptr` is set to (i+1) mod N.
- **Buffer drain.** If the cache acks and nothing is granted, the buffer clears to 0. If nothing is granted and no ack arrives, the buffer holds.
- **Return path.** Each requester has a one-entry return buffer driving its slice of `return_packet_flatted_out`. A return buffer clears at an edge where its ack input is high.
- **Return accept.** A valid cache return packet with port ID p < N, while `return_packet_ack_to_cache_out` is 0, is accepted when buffer p is empty or being acked at that edge. On accept, the packet is written to buffer p and `return_packet_ack_to_cache_out` pulses for one cycle.
- **Bad port ID.** A valid return packet with p ≥ N is acked (pulse) and dropped, and `port_id_error_out` is set.
- **Independence.** The request and return paths are independent, and both may transfer in the same cycle.

## Timing
- **Reset.** On reset assertion, asynchronously:
  - all packet buffers → 0;
  - all ack outputs → 0;
  - `rr_ptr` → 0;
  - `port_id_error_out` → 0.
- **Request latency.** A request valid before edge E and granted at E appears at `request_packet_to_cache_out` and ack is high during cycle E..E+1. The requester must drop or replace its packet at E+1.
- **Throughput.** The request path sustains one packet per cycle aggregate when the cache acks every cycle. Each single requester is limited to one packet per 2 cycles by the ack mask.
- **Return latency.** A return packet accepted at edge E appears at the requester during cycle E..E+1, with the cache ack high in the same cycle.
- **Blocked return.** If the destination return buffer is full and not acked, the cache's return packet waits with no ack. There is no reordering and no head-of-line bypass.
- **Single requester.** If only one requester is eligible, it is granted regardless of `rr_ptr`.
- **Reset mid-transfer.** Reset asserted mid-transfer discards buffered packets. Requesters must reissue them.

## Structure
- Packet field position macros (`VALID_POS`, `PORT_ID_POS_LO/HI`) come from `parameters.h`.
- One sub-module: `round_robin_picker`. It is combinational, takes the eligible vector and `rr_ptr`, and outputs a one-hot grant plus its index.
- All state (buffers, pointer, acks, error flag) lives in this module.

## Test plan
- **Single requester.** Requester 2 sends valid address 0x1000 with port ID 0; cache acks the next cycle. → Cache sees port ID 2; `request_packet_ack_flatted_out` = 4'b0100 for exactly 1 cycle; output buffer returns to 0 after the ack.
- **All requesters contending.** All 4 requesters hold valid packets continuously; cache acks every cycle. → Grant order is 0,1,2,3,0…; each requester is acked once per 4 grants; no packet is duplicated.
- **Return routing.** Cache returns packets with port IDs 1 and 3 on consecutive cycles; requesters ack immediately. → Data appears on slices 1 and 3 only; 2 cache-ack pulses.
- **Return back-pressure.** Return for port 0 while requester 0 withholds its ack for 5 cycles, followed by a second return for port 0. → The second packet gets no cache ack until 1 cycle after requester 0 acks; the first packet is not overwritten.
- **Bad port ID.** Return packet with port ID 7 (N=4). → One cache-ack pulse; all return slices stay 0; `port_id_error_out` rises and stays 1 until reset.
- **Asynchronous reset mid-operation.** Drive `reset_in` low mid-cycle while a packet is buffered. → All outputs are 0 immediately, before the next clock edge; after release the next grant goes to requester 0.
